dual_issue_fetch_queue: RTL

- Instruction fetch stage directly upstream of the dual-issue decode/hazard-control unit.
- Streams 16-bit instructions from synchronous instruction memory into a circular queue.
- Presents the two oldest entries each cycle as slot p0 (older) and slot p1 (younger), with their PCs.
- Decode reports how many entries it consumed; branch redirects flush the queue.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/dual_issue_fetch_queue_if.sv | 37 +++
 rtl/fq_ptr_ctrl.sv | 45 ++++
 rtl/dual_issue_fetch_queue.sv | 105 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch queue
package fetch_pkg;
  localparam int INSN_W   = 16;
  localparam int MAX_PC_W = 16;
  localparam logic [INSN_W-1:0] NOP_IR = 16'h0000;

  typedef logic [1:0] issue_cnt_t;

  // pc is stored at MAX_PC_W; the top narrows it to its own PC_W on read
  typedef struct packed {
    logic [INSN_W-1:0]   ir;
    logic [MAX_PC_W-1:0] pc;
  } fq_entry_t;

  function automatic logic [1:0] clamp_issue(input issue_cnt_t c);
    return (c == 2'd3) ? 2'd2 : c;
  endfunction
endpackage

// File: rtl/dual_issue_fetch_queue_if.sv
// rtl/dual_issue_fetch_queue_if.sv - memory, control and issue-slot signals of the fetch queue
interface dual_issue_fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 9
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              mem_req;
  logic [PC_W-1:0]   mem_addr;
  logic [INSN_W-1:0] mem_rdata;
  logic              halt;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  issue_cnt_t        issue_cnt;
  logic              p0_valid;
  logic              p1_valid;
  logic [INSN_W-1:0] p0_ir;
  logic [INSN_W-1:0] p1_ir;
  logic [PC_W-1:0]   p0_pc;
  logic [PC_W-1:0]   p1_pc;
  logic              fetch_next;
  logic [CNT_W-1:0]  q_count;

  modport master (
    output mem_req, mem_addr, p0_valid, p1_valid, p0_ir, p1_ir, p0_pc, p1_pc,
           fetch_next, q_count,
    input  mem_rdata, halt, redirect, redirect_pc, issue_cnt
  );

  modport slave (
    input  mem_req, mem_addr, p0_valid, p1_valid, p0_ir, p1_ir, p0_pc, p1_pc,
           fetch_next, q_count,
    output mem_rdata, halt, redirect, redirect_pc, issue_cnt
  );
endinterface

// File: rtl/fq_ptr_ctrl.sv
// rtl/fq_ptr_ctrl.sv - head/tail/count bookkeeping with clamped consume and flush priority
module fq_ptr_ctrl
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  issue_cnt_t       issue_cnt,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       consumed
);
  logic [1:0] req;

  // Consume never exceeds occupancy; a flush swallows the request entirely
  always_comb begin
    req      = clamp_issue(issue_cnt);
    consumed = 2'd0;
    if (!flush) begin
      consumed = (CNT_W'(req) > count) ? count[1:0] : req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(consumed);
      tail  <= tail + PTR_W'(wr_en);
      count <= count + CNT_W'(wr_en) - CNT_W'(consumed);
    end
  end
endmodule

// File: rtl/dual_issue_fetch_queue.sv
// rtl/dual_issue_fetch_queue.sv - fetch queue feeding two issue slots; FETCH_BYPASS_EN adds empty-queue bypass
module dual_issue_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  dual_issue_fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  req_pc;
  logic             inflight;
  logic             resp_keep;
  logic             wr_en;
  logic             bypass_vld;
  logic             bypass_take;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] occ;
  logic [1:0]       consumed;
  fq_entry_t        entries [DEPTH];

  // A redirect in the response cycle acts as the drop flag for that word
  assign resp_keep    = inflight && !bus.redirect;
  assign occ          = count + CNT_W'(inflight);
  assign bus.mem_req  = rst_n && !bus.halt && !bus.redirect && (occ < CNT_W'(DEPTH));
  assign bus.mem_addr = fetch_pc;

`ifdef FETCH_BYPASS_EN
  assign bypass_vld  = resp_keep && (count == '0);
  assign bypass_take = bypass_vld && (bus.issue_cnt != 2'd0);
`else
  assign bypass_vld  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign wr_en = resp_keep && !bypass_take;

  fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.redirect),
    .wr_en    (wr_en),
    .issue_cnt(bus.issue_cnt),
    .head     (head),
    .tail     (tail),
    .count    (count),
    .consumed (consumed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= bus.mem_req;
      if (bus.mem_req) begin
        req_pc <= fetch_pc;
      end
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc;
      end else if (bus.mem_req) begin
        fetch_pc <= fetch_pc + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (wr_en) begin
      entries[tail] <= '{ir: bus.mem_rdata, pc: MAX_PC_W'(req_pc)};
    end
  end

  assign head_nxt = head + PTR_W'(1);

  always_comb begin
    bus.p0_valid = (count != '0) || bypass_vld;
    bus.p0_ir    = NOP_IR;
    bus.p0_pc    = entries[head].pc[PC_W-1:0];
    if (bypass_vld) begin
      bus.p0_ir = bus.mem_rdata;
      bus.p0_pc = req_pc;
    end else if (count != '0) begin
      bus.p0_ir = entries[head].ir;
    end
    bus.p1_valid   = (count >= CNT_W'(2));
    bus.p1_ir      = bus.p1_valid ? entries[head_nxt].ir : NOP_IR;
    bus.p1_pc      = entries[head_nxt].pc[PC_W-1:0];
    bus.fetch_next = (consumed != 2'd0) || bypass_take;
    bus.q_count    = count;
  end
endmodule
